// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_sequencer
// Description : Multi-cycle 32-bit restoring divider for DIV/DIVU/REM/REMU
//               with RISC-V M-extension divide-by-zero and overflow results.
//               Optional macro: DIV_SEQ_EARLY_OUT_EN (special cases skip CALC).
// Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [4:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic        FLUSH,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [4:0]  c_LAST_ITER = 5'd31;
    localparam logic [31:0] c_ALL_ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [31:0] r_dvd_raw;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_ovf;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_valid_op;
    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_div_zero;
    logic        w_ovf;
    logic [32:0] w_rem_sh;
    logic [31:0] w_sub;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_signed;
    logic [31:0] w_rem_signed;
    logic [31:0] w_fix_result;

    // Opcode decode: 111xy, x=0 signed, y=1 remainder
    assign w_valid_op = (SELECT[4:2] == 3'b111);
    assign w_signed   = ~SELECT[1];
    assign w_abs_a    = (w_signed && DATA1[31]) ? (~DATA1 + 32'd1) : DATA1;
    assign w_abs_b    = (w_signed && DATA2[31]) ? (~DATA2 + 32'd1) : DATA2;
    assign w_div_zero = (DATA2 == 32'd0);
    assign w_ovf      = w_signed && (DATA1 == c_INT_MIN) && (DATA2 == c_ALL_ONES);

    // One restoring step: the partial remainder can momentarily need 33 bits
    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_div});
    assign w_sub      = w_rem_sh[31:0] - r_div;
    assign w_rem_next = w_ge ? w_sub : w_rem_sh[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    assign w_quo_signed = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign w_rem_signed = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // Special cases are always forced here so the early-out path needs no datapath work
    always_comb begin
        w_fix_result = r_is_rem ? w_rem_signed : w_quo_signed;
        if (r_div_zero) begin
            w_fix_result = r_is_rem ? r_dvd_raw : c_ALL_ONES;
        end else if (r_ovf) begin
            w_fix_result = r_is_rem ? 32'd0 : c_INT_MIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_IDLE;
            r_cnt      <= 5'd0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_div      <= 32'd0;
            r_dvd_raw  <= 32'd0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (START && w_valid_op) begin
                        r_is_rem   <= SELECT[0];
                        r_neg_q    <= w_signed && (DATA1[31] ^ DATA2[31]);
                        r_neg_r    <= w_signed && DATA1[31];
                        r_quo      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_rem      <= 32'd0;
                        r_cnt      <= 5'd0;
                        r_dvd_raw  <= DATA1;
                        r_div_zero <= w_div_zero;
                        r_ovf      <= w_ovf;
`ifdef DIV_SEQ_EARLY_OUT_EN
                        r_state    <= (w_div_zero || w_ovf) ? c_FIX : c_CALC;
`else
                        r_state    <= c_CALC;
`endif
                    end
                end
                c_CALC: begin
                    if (FLUSH) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == c_LAST_ITER) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    if (!FLUSH) begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = (r_state != c_IDLE);
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide/remainder unit for the RISC-V pipeline's execute stage. It takes the divide-class ALU opcodes (DIV, DIVU, REM, REMU) off the single-cycle ALU path and runs them as a 32-iteration restoring division. The execute stage issues with START, holds the pipeline while BUSY is high, and captures RESULT on the one-cycle DONE pulse. The block implements RISC-V M-extension results for divide-by-zero and signed overflow exactly.

## Interface
- No parameters; datapath width fixed at 32.
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  issue request; sampled only in IDLE.
- SELECT  input  5  ALU opcode: 11100 DIV, 11110 DIVU, 11101 REM, 11111 REMU.
- DATA1  input  32  dividend; sampled with START.
- DATA2  input  32  divisor; sampled with START.
- FLUSH  input  1  pipeline flush; aborts an in-flight operation.
- BUSY  output  1  operation in flight; the execute stage stalls while high.
- DONE  output  1  one-cycle pulse; RESULT is valid in this cycle.
- RESULT  output  32  quotient or remainder; held until the next DONE.

## Operation
- **States:** IDLE, CALC, FIX.
- **Reset:** state IDLE; BUSY=0, DONE=0, RESULT=0, iteration counter=0. RESET overrides START and FLUSH.
- **IDLE, START=1 with a valid divide opcode:**
  - Latch op type and signedness (SELECT[1]=0 means signed).
  - Latch the operand signs and |DATA1|, |DATA2| (absolute values only for signed ops).
  - Clear the partial remainder; set the counter to 0; go to CALC.
- **IDLE, START=1 with any other opcode:** ignored. No BUSY, no DONE.
- **CALC, one iteration per cycle:**
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor, then rem -= divisor and quo[0]=1.
  - After the 32nd iteration (counter==31), go to FIX.
- **FIX (single cycle):** apply signs and write RESULT, then go to IDLE.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- **Special cases (final RESULT):**
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - The iterative datapath must produce these values, or FIX must override them.
- **FLUSH:** if asserted in CALC or FIX, go to IDLE next edge. No DONE, RESULT unchanged. FLUSH in IDLE has no effect; START in the same cycle as FLUSH in IDLE is accepted.
- **Back-pressure:** START while BUSY=1 is ignored; no queueing.

## Timing
- The START cycle is cycle 0; START is sampled at edge 0.
- BUSY is high in cycles 1..33.
- CALC runs at edges 1..32. FIX registers RESULT and DONE at edge 33.
- DONE=1 and BUSY=0 in cycle 34, so latency is 34 cycles.
- DONE is registered, never combinational. It is high for exactly one cycle.
- The state is IDLE while DONE=1, so a new START in the DONE cycle is accepted; back-to-back throughput is one op per 34 cycles.
- Operands may change after the START cycle; only latched copies are used.
- RESET or FLUSH asserted at edge n: BUSY=0 from cycle n+1.

## Configuration
- **DIV_SEQ_EARLY_OUT_EN defined:** at START, a zero divisor or signed overflow goes directly to FIX and skips CALC. BUSY is high in cycle 1 only; DONE is high in cycle 2. RESULT values are identical to the full path.
- **Not defined:** every accepted op takes 34 cycles regardless of operands.

## Test plan
- DIV 100 / -7: START at cycle 0 → DONE in cycle 34 with RESULT=0xFFFFFFF2 (-14). REM of the same operands → RESULT=0x00000002.
- DIVU 0xFFFFFFFF / 2 → RESULT=0x7FFFFFFF. REMU 7 / 0 → RESULT=7. DIV 5 / 0 → RESULT=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0.
- With DIV_SEQ_EARLY_OUT_EN: DIV 5 / 0 → DONE in cycle 2. Without it → DONE in cycle 34. RESULT is the same in both builds.
- START (DIV 9/3) at cycle 0, then START (REM 9/4) at cycle 5 → second START ignored; one DONE in cycle 34 with RESULT=3.
- Then START (REM 9/4) in the DONE cycle → accepted; next DONE 34 cycles later with RESULT=1.
- FLUSH at cycle 10 mid-CALC → BUSY=0 from cycle 11, no DONE, RESULT keeps its prior value. RESET at cycle 20 of a second op → all outputs 0 next cycle.
- START with SELECT=00000 (ADD) → BUSY stays 0 and no DONE within 40 cycles.
